// File: rtl/uart_rx.sv
// -----------------------------------------------------------------------------
// uart_rx -- 8-bit asynchronous serial receiver, LSB first, 16x-style
// oversampling by a programmable clock divider with mid-bit sampling.
//
// Optional feature (compile-time macro UART_RX_PARITY_EN):
//   defined   : frame = start, 8 data, parity, stop; parity is checked.
//   undefined : frame = start, 8 data, stop; i_par_typ is ignored and
//               o_par_err is tied low.
//
// Parameters
//   CLK_DIV      clock cycles per serial bit (even, >= 4)
//
// Ports
//   i_clk        clock, all state updates on the rising edge
//   i_rst        synchronous active-high reset
//   i_rx         asynchronous serial line, idles high
//   i_par_typ    parity type: 1 = ODD, 0 = EVEN (latched at start confirm)
//   o_p_data     last received byte (held until next delivery)
//   o_data_valid one-cycle pulse when o_p_data and the error flags update
//   o_par_err    parity mismatch for the delivered byte
//   o_frame_err  stop bit sampled low for the delivered byte
//   o_busy       high whenever the receiver is not idle
// -----------------------------------------------------------------------------
module uart_rx #(
    parameter int CLK_DIV = 16
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_rx,
    input  logic       i_par_typ,
    output logic [7:0] o_p_data,
    output logic       o_data_valid,
    output logic       o_par_err,
    output logic       o_frame_err,
    output logic       o_busy
);

    localparam int CW = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
    localparam logic [CW-1:0] CYC_HALF_M1 = CW'(CLK_DIV / 2 - 1);
    localparam logic [CW-1:0] CYC_LAST    = CW'(CLK_DIV - 1);
    localparam logic [CW-1:0] CYC_ONE     = CW'(1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
`ifdef UART_RX_PARITY_EN
        S_PARITY,
`endif
        S_STOP
    } state_e;

    state_e        state_q, state_d;
    logic [CW-1:0] cyc_q, cyc_d;
    logic [2:0]    bit_q, bit_d;
    logic [7:0]    shift_q, shift_d;
    logic          armed_q, armed_d;

    // Two-flop synchronizer plus one history flop for falling-edge detect.
    logic          rx_meta_q, rx_sync_q, rx_prev_q;

    logic [7:0]    data_q, data_d;
    logic          frame_err_q, frame_err_d;
    logic          valid_q, valid_d;

`ifdef UART_RX_PARITY_EN
    logic          par_typ_q, par_typ_d;
    logic          par_bit_q, par_bit_d;
    logic          par_err_q, par_err_d;

    // Expected parity bit for the given type: ODD makes the total count of
    // ones (data + parity) odd, EVEN makes it even.
    function automatic logic exp_parity(input logic odd, input logic [7:0] d);
        return odd ? ~^d : ^d;
    endfunction
`else
    logic          unused_par_typ;
    assign unused_par_typ = i_par_typ;
`endif

    wire start_edge = rx_prev_q & ~rx_sync_q & armed_q;

    always_comb begin
        state_d     = state_q;
        cyc_d       = cyc_q;
        bit_d       = bit_q;
        shift_d     = shift_q;
        armed_d     = armed_q;
        data_d      = data_q;
        frame_err_d = frame_err_q;
        valid_d     = 1'b0;
`ifdef UART_RX_PARITY_EN
        par_typ_d   = par_typ_q;
        par_bit_d   = par_bit_q;
        par_err_d   = par_err_q;
`endif

        // The line re-arms as soon as it is seen high; only a framing
        // error (below) can disarm it.
        if (rx_sync_q) begin
            armed_d = 1'b1;
        end

        case (state_q)
            S_IDLE: begin
                cyc_d = '0;
                bit_d = '0;
                if (start_edge) begin
                    state_d = S_START;
                end
            end

            S_START: begin
                if (cyc_q == CYC_HALF_M1) begin
                    cyc_d = '0;
                    if (!rx_sync_q) begin
                        state_d = S_DATA;
                        bit_d   = '0;
`ifdef UART_RX_PARITY_EN
                        par_typ_d = i_par_typ;
`endif
                    end else begin
                        // Line went back high before mid-start: glitch.
                        state_d = S_IDLE;
                    end
                end else begin
                    cyc_d = cyc_q + CYC_ONE;
                end
            end

            S_DATA: begin
                if (cyc_q == CYC_LAST) begin
                    cyc_d   = '0;
                    shift_d = {rx_sync_q, shift_q[7:1]};
                    if (bit_q == 3'd7) begin
                        bit_d = '0;
`ifdef UART_RX_PARITY_EN
                        state_d = S_PARITY;
`else
                        state_d = S_STOP;
`endif
                    end else begin
                        bit_d = bit_q + 3'd1;
                    end
                end else begin
                    cyc_d = cyc_q + CYC_ONE;
                end
            end

`ifdef UART_RX_PARITY_EN
            S_PARITY: begin
                if (cyc_q == CYC_LAST) begin
                    cyc_d     = '0;
                    par_bit_d = rx_sync_q;
                    state_d   = S_STOP;
                end else begin
                    cyc_d = cyc_q + CYC_ONE;
                end
            end
`endif

            S_STOP: begin
                if (cyc_q == CYC_LAST) begin
                    cyc_d       = '0;
                    state_d     = S_IDLE;
                    valid_d     = 1'b1;
                    data_d      = shift_q;
                    frame_err_d = ~rx_sync_q;
`ifdef UART_RX_PARITY_EN
                    par_err_d   = par_bit_q ^ exp_parity(par_typ_q, shift_q);
`endif
                    // A low stop bit means the line may still be low (break
                    // or misalignment): do not accept a start until it has
                    // been seen high again.
                    if (!rx_sync_q) begin
                        armed_d = 1'b0;
                    end
                end else begin
                    cyc_d = cyc_q + CYC_ONE;
                end
            end

            default: begin
                state_d = S_IDLE;
                cyc_d   = '0;
                bit_d   = '0;
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            rx_meta_q   <= 1'b1;
            rx_sync_q   <= 1'b1;
            rx_prev_q   <= 1'b1;
            state_q     <= S_IDLE;
            cyc_q       <= '0;
            bit_q       <= '0;
            shift_q     <= '0;
            armed_q     <= 1'b0;
            data_q      <= '0;
            frame_err_q <= 1'b0;
            valid_q     <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par_typ_q   <= 1'b0;
            par_bit_q   <= 1'b0;
            par_err_q   <= 1'b0;
`endif
        end else begin
            rx_meta_q   <= i_rx;
            rx_sync_q   <= rx_meta_q;
            rx_prev_q   <= rx_sync_q;
            state_q     <= state_d;
            cyc_q       <= cyc_d;
            bit_q       <= bit_d;
            shift_q     <= shift_d;
            armed_q     <= armed_d;
            data_q      <= data_d;
            frame_err_q <= frame_err_d;
            valid_q     <= valid_d;
`ifdef UART_RX_PARITY_EN
            par_typ_q   <= par_typ_d;
            par_bit_q   <= par_bit_d;
            par_err_q   <= par_err_d;
`endif
        end
    end

    assign o_p_data     = data_q;
    assign o_data_valid = valid_q;
    assign o_frame_err  = frame_err_q;
    assign o_busy       = (state_q != S_IDLE);
`ifdef UART_RX_PARITY_EN
    assign o_par_err    = par_err_q;
`else
    assign o_par_err    = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx.sv
module tb_uart_rx;

    localparam int CLK_DIV = 16;
`ifdef UART_RX_PARITY_EN
    localparam int FRAME_BITS = 11;
    localparam bit PAR_EN     = 1'b1;
`else
    localparam int FRAME_BITS = 10;
    localparam bit PAR_EN     = 1'b0;
`endif

    logic       i_clk = 1'b0;
    logic       i_rst;
    logic       i_rx;
    logic       i_par_typ;
    logic [7:0] o_p_data;
    logic       o_data_valid;
    logic       o_par_err;
    logic       o_frame_err;
    logic       o_busy;

    uart_rx #(.CLK_DIV(CLK_DIV)) dut (
        .i_clk        (i_clk),
        .i_rst        (i_rst),
        .i_rx         (i_rx),
        .i_par_typ    (i_par_typ),
        .o_p_data     (o_p_data),
        .o_data_valid (o_data_valid),
        .o_par_err    (o_par_err),
        .o_frame_err  (o_frame_err),
        .o_busy       (o_busy)
    );

    always #5 i_clk = ~i_clk;

    typedef struct packed {
        logic [7:0] data;
        logic       par_err;
        logic       frame_err;
    } exp_t;

    exp_t exp_q[$];
    int   pulse_cyc[$];
    int   cyc_cnt = 0;
    int   n_tests = 0;
    int   n_fail  = 0;
    int   n_sent  = 0;
    logic prev_vld = 1'b0;
    exp_t mon_e;

    always @(posedge i_clk) cyc_cnt <= cyc_cnt + 1;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, obs, exp, cyc_cnt);
        end
    endtask

    // Scoreboard: every delivery is matched against the oldest outstanding
    // expectation.
    always @(negedge i_clk) begin
        if (o_data_valid === 1'b1) begin
            pulse_cyc.push_back(cyc_cnt);
            check_eq("vld_single_cycle", {31'd0, prev_vld}, 32'd0);
            if (exp_q.size() == 0) begin
                check_eq("unexpected_vld", {31'd0, o_data_valid}, 32'd0);
            end else begin
                mon_e = exp_q.pop_front();
                check_eq("data",      {24'd0, o_p_data},    {24'd0, mon_e.data});
                check_eq("par_err",   {31'd0, o_par_err},   {31'd0, mon_e.par_err});
                check_eq("frame_err", {31'd0, o_frame_err}, {31'd0, mon_e.frame_err});
            end
        end
        prev_vld = o_data_valid;
    end

    task automatic wait_cyc(input int n);
        repeat (n) @(posedge i_clk);
        #1;
    endtask

    task automatic drive_bit(input logic b);
        i_rx = b;
        wait_cyc(CLK_DIV);
    endtask

    task automatic send_frame(input logic [7:0] d, input logic par_bit, input logic stop_bit,
                              input logic typ, input logic flip);
        exp_t e;
        e.data      = d;
        e.frame_err = ~stop_bit;
        e.par_err   = PAR_EN ? (par_bit ^ (typ ? ~^d : ^d)) : 1'b0;
        exp_q.push_back(e);
        n_sent++;
        i_par_typ = typ;
        drive_bit(1'b0);
        if (flip) i_par_typ = ~typ;
        for (int i = 0; i < 8; i++) drive_bit(d[i]);
`ifdef UART_RX_PARITY_EN
        drive_bit(par_bit);
`endif
        drive_bit(stop_bit);
    endtask

    task automatic drain(input string tag);
        int t = 0;
        while (exp_q.size() != 0 && t < 2000) begin
            wait_cyc(1);
            t++;
        end
        if (exp_q.size() != 0) begin
            check_eq(tag, exp_q.size(), 0);
            exp_q.delete();
        end
    endtask

    task automatic check_all_zero(input string tag);
        check_eq({tag, "_data"},  {24'd0, o_p_data},     32'd0);
        check_eq({tag, "_vld"},   {31'd0, o_data_valid}, 32'd0);
        check_eq({tag, "_par"},   {31'd0, o_par_err},    32'd0);
        check_eq({tag, "_frame"}, {31'd0, o_frame_err},  32'd0);
        check_eq({tag, "_busy"},  {31'd0, o_busy},       32'd0);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int n0;
        i_rst     = 1'b1;
        i_rx      = 1'b1;
        i_par_typ = 1'b0;
        wait_cyc(5);
        check_all_zero("reset");
        i_rst = 1'b0;
        wait_cyc(10);

        // Good frame, even parity.
        send_frame(8'hA5, 1'b0, 1'b1, 1'b0, 1'b0);
        wait_cyc(20);
        drain("drain_a5_ok");

        // Parity bit wrong for EVEN type.
        send_frame(8'hA5, 1'b1, 1'b1, 1'b0, 1'b0);
        drain("drain_a5_perr");
        wait_cyc(40);
        check_eq("hold_data", {24'd0, o_p_data}, 32'hA5);
        check_eq("hold_par",  {31'd0, o_par_err}, {31'd0, PAR_EN});

        // Parity type flipped after start confirmation must be ignored.
        send_frame(8'h3B, 1'b1, 1'b1, 1'b0, 1'b1);
        wait_cyc(20);
        drain("drain_flip");

        // Framing error; line stays low afterwards.
        send_frame(8'h01, 1'b0, 1'b0, 1'b1, 1'b0);
        wait_cyc(48);
        check_eq("disarmed_busy", {31'd0, o_busy}, 32'd0);
        drain("drain_ferr");
        i_rx = 1'b1;
        wait_cyc(32);
        send_frame(8'h5A, 1'b1, 1'b1, 1'b1, 1'b0);
        wait_cyc(20);
        drain("drain_recover");

        // Short glitch on the line: no delivery, busy drops again.
        n0 = pulse_cyc.size();
        i_rx = 1'b0;
        wait_cyc(4);
        i_rx = 1'b1;
        check_eq("glitch_busy_hi", {31'd0, o_busy}, 32'd1);
        wait_cyc(40);
        check_eq("glitch_busy_lo", {31'd0, o_busy}, 32'd0);
        check_eq("glitch_no_vld", pulse_cyc.size() - n0, 0);

        // Reset in the middle of bit 3, then a clean frame.
        drive_bit(1'b0);
        drive_bit(1'b1);
        drive_bit(1'b0);
        drive_bit(1'b1);
        i_rx = 1'b1;
        wait_cyc(8);
        i_rst = 1'b1;
        wait_cyc(1);
        check_all_zero("midrst");
        i_rst = 1'b0;
        wait_cyc(40);
        check_eq("midrst_no_vld", {31'd0, o_data_valid}, 32'd0);
        send_frame(8'h3C, 1'b0, 1'b1, 1'b0, 1'b0);
        wait_cyc(20);
        drain("drain_3c");

        // Back-to-back frames.
        wait_cyc(10);
        n0 = pulse_cyc.size();
        send_frame(8'h55, 1'b0, 1'b1, 1'b0, 1'b0);
        send_frame(8'hAA, 1'b0, 1'b1, 1'b0, 1'b0);
        wait_cyc(20);
        drain("drain_b2b");
        check_eq("b2b_count", pulse_cyc.size() - n0, 2);
        if (pulse_cyc.size() >= n0 + 2)
            check_eq("b2b_gap", pulse_cyc[n0+1] - pulse_cyc[n0], FRAME_BITS * CLK_DIV);

        wait_cyc(20);
        check_eq("total_pulses", pulse_cyc.size(), n_sent);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
